// File: rtl/ram_access_ctrl.sv
// Sequencing controller and two-requester arbiter for the 8x16 register RAM.
// Serialises write-back and operand-read requests and returns captured read data via req/ack.
module ram_access_ctrl #(
    parameter int unsigned mem_width  = 16,
    parameter int unsigned add_length = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [add_length-1:0] wr_sel,
    input  logic [mem_width-1:0]  wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic [add_length-1:0] rd_sel_a,
    input  logic [add_length-1:0] rd_sel_b,
    output logic                  rd_ack,
    output logic [mem_width-1:0]  rd_data_a,
    output logic [mem_width-1:0]  rd_data_b,
    output logic                  ram_ce,
    output logic                  ram_rr,
    output logic [add_length-1:0] ram_in_sel,
    output logic [mem_width-1:0]  ram_in_data,
    output logic [add_length-1:0] ram_out_1_sel,
    output logic [add_length-1:0] ram_out_2_sel,
    input  logic [mem_width-1:0]  ram_out_1,
    input  logic [mem_width-1:0]  ram_out_2,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    typedef enum logic {
        GRANT_WR,
        GRANT_RD
    } grant_t;

    state_t                state, state_nxt;
    grant_t                last_grant, last_grant_nxt;
    logic                  grant_wr, grant_rd, addr_conflict;
    logic [add_length-1:0] in_sel_nxt, out_1_sel_nxt, out_2_sel_nxt;
    logic [mem_width-1:0]  in_data_nxt, rd_data_a_nxt, rd_data_b_nxt;
    logic                  ce_nxt, rr_nxt, wr_ack_nxt, rd_ack_nxt, busy_nxt;

    // Next-state, arbitration and next values of every registered output
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_wr       = 1'b0;
        grant_rd       = 1'b0;
        in_sel_nxt     = ram_in_sel;
        in_data_nxt    = ram_in_data;
        out_1_sel_nxt  = ram_out_1_sel;
        out_2_sel_nxt  = ram_out_2_sel;
        rd_data_a_nxt  = rd_data_a;
        rd_data_b_nxt  = rd_data_b;
        addr_conflict  = (rd_sel_a == wr_sel) || (rd_sel_b == wr_sel);

        case (state)
            ST_IDLE: begin
                // Write wins a tie on address overlap so the read sees fresh data
                if (wr_req && rd_req) begin
                    if (addr_conflict || (last_grant == GRANT_RD)) grant_wr = 1'b1;
                    else                                           grant_rd = 1'b1;
                end else if (wr_req) begin
                    grant_wr = 1'b1;
                end else if (rd_req) begin
                    grant_rd = 1'b1;
                end

                if (grant_wr) begin
                    state_nxt      = ST_WRITE;
                    last_grant_nxt = GRANT_WR;
                    in_sel_nxt     = wr_sel;
                    in_data_nxt    = wr_data;
                end else if (grant_rd) begin
                    state_nxt      = ST_READ;
                    last_grant_nxt = GRANT_RD;
                    out_1_sel_nxt  = rd_sel_a;
                    out_2_sel_nxt  = rd_sel_b;
                end
            end
            ST_WRITE: state_nxt = ST_IDLE;
            ST_READ:  state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                // RAM outputs are only valid during this one cycle
                rd_data_a_nxt = ram_out_1;
                rd_data_b_nxt = ram_out_2;
                state_nxt     = ST_RESP;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        ce_nxt     = (state_nxt == ST_WRITE) || (state_nxt == ST_READ);
        rr_nxt     = (state_nxt == ST_WRITE);
        wr_ack_nxt = (state_nxt == ST_WRITE);
        rd_ack_nxt = (state_nxt == ST_RESP);
        busy_nxt   = (state_nxt != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            last_grant    <= GRANT_RD;
            ram_ce        <= 1'b0;
            ram_rr        <= 1'b0;
            wr_ack        <= 1'b0;
            rd_ack        <= 1'b0;
            busy          <= 1'b0;
            ram_in_sel    <= '0;
            ram_in_data   <= '0;
            ram_out_1_sel <= '0;
            ram_out_2_sel <= '0;
            rd_data_a     <= '0;
            rd_data_b     <= '0;
        end else begin
            state         <= state_nxt;
            last_grant    <= last_grant_nxt;
            ram_ce        <= ce_nxt;
            ram_rr        <= rr_nxt;
            wr_ack        <= wr_ack_nxt;
            rd_ack        <= rd_ack_nxt;
            busy          <= busy_nxt;
            ram_in_sel    <= in_sel_nxt;
            ram_in_data   <= in_data_nxt;
            ram_out_1_sel <= out_1_sel_nxt;
            ram_out_2_sel <= out_2_sel_nxt;
            rd_data_a     <= rd_data_a_nxt;
            rd_data_b     <= rd_data_b_nxt;
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 8x16 two-read-port register RAM.
module tb_ram_access_ctrl;

    localparam int unsigned MW = 16;
    localparam int unsigned AL = 3;
    localparam logic [MW-1:0] POISON = 16'hF00F;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req, rd_req;
    logic [AL-1:0] wr_sel, rd_sel_a, rd_sel_b;
    logic [MW-1:0] wr_data;
    logic          wr_ack, rd_ack;
    logic [MW-1:0] rd_data_a, rd_data_b;
    logic          ram_ce, ram_rr;
    logic [AL-1:0] ram_in_sel, ram_out_1_sel, ram_out_2_sel;
    logic [MW-1:0] ram_in_data, ram_out_1, ram_out_2;
    logic          busy;

    int n_vec  = 0;
    int n_miss = 0;

    logic [MW-1:0] mem [8];

    always #5 clk = ~clk;

    ram_access_ctrl #(.mem_width(MW), .add_length(AL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_req        (wr_req),
        .wr_sel        (wr_sel),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .rd_req        (rd_req),
        .rd_sel_a      (rd_sel_a),
        .rd_sel_b      (rd_sel_b),
        .rd_ack        (rd_ack),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .ram_ce        (ram_ce),
        .ram_rr        (ram_rr),
        .ram_in_sel    (ram_in_sel),
        .ram_in_data   (ram_in_data),
        .ram_out_1_sel (ram_out_1_sel),
        .ram_out_2_sel (ram_out_2_sel),
        .ram_out_1     (ram_out_1),
        .ram_out_2     (ram_out_2),
        .busy          (busy)
    );

    // RAM model: outputs valid only in the cycle after a read, poisoned otherwise
    always @(posedge clk) begin
        if (ram_ce && ram_rr) mem[ram_in_sel] <= ram_in_data;
        if (ram_ce && !ram_rr) begin
            ram_out_1 <= mem[ram_out_1_sel];
            ram_out_2 <= mem[ram_out_2_sel];
        end else begin
            ram_out_1 <= POISON;
            ram_out_2 <= POISON;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AL-1:0] sel, input logic [MW-1:0] data);
        wr_sel  = sel;
        wr_data = data;
        wr_req  = 1'b1;
        tick();
        check("wr_ack", 32'(wr_ack), 32'd1);
        check("wr_ce", 32'(ram_ce), 32'd1);
        check("wr_rr", 32'(ram_rr), 32'd1);
        check("wr_in_sel", 32'(ram_in_sel), 32'(sel));
        check("wr_in_data", 32'(ram_in_data), 32'(data));
        check("wr_busy", 32'(busy), 32'd1);
        tick();
        wr_req = 1'b0;
        check("wr_ack_drop", 32'(wr_ack), 32'd0);
        check("wr_busy_drop", 32'(busy), 32'd0);
        check("wr_ce_drop", 32'(ram_ce), 32'd0);
    endtask

    task automatic do_read(input logic [AL-1:0] a, input logic [AL-1:0] b,
                           input logic [MW-1:0] ea, input logic [MW-1:0] eb);
        rd_sel_a = a;
        rd_sel_b = b;
        rd_req   = 1'b1;
        tick();
        check("rd_ce", 32'(ram_ce), 32'd1);
        check("rd_rr", 32'(ram_rr), 32'd0);
        check("rd_sel1", 32'(ram_out_1_sel), 32'(a));
        check("rd_sel2", 32'(ram_out_2_sel), 32'(b));
        check("rd_ack_early", 32'(rd_ack), 32'd0);
        tick();
        check("cap_ce", 32'(ram_ce), 32'd0);
        check("cap_ack", 32'(rd_ack), 32'd0);
        check("cap_busy", 32'(busy), 32'd1);
        tick();
        rd_req = 1'b0;
        check("rd_ack", 32'(rd_ack), 32'd1);
        check("rd_data_a", 32'(rd_data_a), 32'(ea));
        check("rd_data_b", 32'(rd_data_b), 32'(eb));
        tick();
        check("rd_ack_drop", 32'(rd_ack), 32'd0);
        check("rd_busy_drop", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pattern;
        int         n_grants;

        for (int i = 0; i < 8; i++) mem[i] = '0;
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_sel = '0; wr_data = '0; rd_sel_a = '0; rd_sel_b = '0;
        repeat (2) tick();
        check("rst_ce", 32'(ram_ce), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({wr_ack, rd_ack, ram_rr}), 32'd0);
        check("rst_rd_data", 32'({rd_data_a, rd_data_b}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write, then write/write/read-back
        do_write(3'd3, 16'hA5A5);
        do_write(3'd2, 16'h1234);
        do_write(3'd5, 16'hBEEF);
        do_read(3'd2, 3'd5, 16'h1234, 16'hBEEF);
        repeat (3) tick();
        check("rd_data_hold", 32'(rd_data_a), 32'h1234);

        // Address conflict: write must win and the read sees the new value
        do_write(3'd4, 16'h0001);
        wr_sel = 3'd4; wr_data = 16'h00FF; wr_req = 1'b1;
        rd_sel_a = 3'd4; rd_sel_b = 3'd0; rd_req = 1'b1;
        tick();
        check("conf_wr_first", 32'({wr_ack, ram_rr}), 32'b11);
        tick();
        wr_req = 1'b0;
        tick();
        check("conf_read", 32'({ram_ce, ram_rr}), 32'b10);
        repeat (2) tick();
        rd_req = 1'b0;
        check("conf_rd_ack", 32'(rd_ack), 32'd1);
        check("conf_rd_data_a", 32'(rd_data_a), 32'h00FF);
        tick();

        // Round-robin with both requests held: W R W R W R over 16 cycles
        do_reset();
        wr_sel = 3'd1; wr_data = 16'h5555; wr_req = 1'b1;
        rd_sel_a = 3'd6; rd_sel_b = 3'd7; rd_req = 1'b1;
        pattern = '0; n_grants = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (wr_ack) begin pattern = {pattern[6:0], 1'b1}; n_grants++; end
            if (ram_ce && !ram_rr) begin pattern = {pattern[6:0], 1'b0}; n_grants++; end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        check("rr_grants", 32'(n_grants), 32'd6);
        check("rr_pattern", 32'(pattern), 32'b0010_1010);
        repeat (4) tick();
        check("rr_idle", 32'(busy), 32'd0);

        // Reset during READ: outputs clear at once, no ack, fresh read works
        rd_sel_a = 3'd2; rd_sel_b = 3'd5; rd_req = 1'b1;
        tick();
        check("rrst_ce_before", 32'(ram_ce), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rrst_ce", 32'(ram_ce), 32'd0);
        check("rrst_busy", 32'(busy), 32'd0);
        check("rrst_sel1", 32'(ram_out_1_sel), 32'd0);
        rd_req = 1'b0;
        tick();
        tick();
        check("rrst_no_ack", 32'(rd_ack), 32'd0);
        rst_n = 1'b1;
        do_read(3'd2, 3'd5, 16'h1234, 16'hBEEF);

        // Reset during WRITE: RAM location must keep its old value
        wr_sel = 3'd0; wr_data = 16'hDEAD; wr_req = 1'b1;
        tick();
        check("wrst_ce_before", 32'(ram_ce), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("wrst_ce", 32'(ram_ce), 32'd0);
        check("wrst_ack", 32'(wr_ack), 32'd0);
        wr_req = 1'b0;
        tick();
        rst_n = 1'b1;
        do_read(3'd0, 3'd0, 16'h0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Sequencing controller and two-requester arbiter for the 8x16 register RAM, which has two registered read ports, one write port, and a single ce/rr mode per cycle. It serialises a write-back requester and an operand-read requester onto the RAM and drives all RAM control, select and data inputs. It also captures the read data, which is valid for only one cycle, and returns it through a req/ack handshake.

Parameters:
mem_width, 16, data word width; must match the RAM.
add_length, 3, address width; must match the RAM.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous reset, active-low.
wr_req  in  1  write request; held with wr_sel/wr_data until wr_ack.
wr_sel  in  add_length  write address.
wr_data  in  mem_width  write data.
wr_ack  out  1  one-cycle pulse; the write is committed at the end of this cycle.
rd_req  in  1  read request; held with rd_sel_a/rd_sel_b until rd_ack.
rd_sel_a  in  add_length  operand A address.
rd_sel_b  in  add_length  operand B address.
rd_ack  out  1  one-cycle pulse; rd_data_a/b are valid this cycle.
rd_data_a  out  mem_width  captured operand A.
rd_data_b  out  mem_width  captured operand B.
ram_ce  out  1  RAM chip enable.
ram_rr  out  1  RAM mode: 1 = write, 0 = read.
ram_in_sel  out  add_length  RAM write address.
ram_in_data  out  mem_width  RAM write data.
ram_out_1_sel  out  add_length  RAM read address, port 1.
ram_out_2_sel  out  add_length  RAM read address, port 2.
ram_out_1  in  mem_width  RAM read data, port 1; high-Z when not reading.
ram_out_2  in  mem_width  RAM read data, port 2.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, WRITE, READ, CAPTURE, RESP. Requests are sampled only in IDLE.
- IDLE:
  - Only wr_req high -> WRITE.
  - Only rd_req high -> READ.
  - Neither high -> stay in IDLE.
  - Both high:
    - If rd_sel_a == wr_sel or rd_sel_b == wr_sel, go to WRITE (write-before-read on address match).
    - Otherwise round-robin: grant the requester not granted last. last_grant is updated on every grant.
  - On the transition into WRITE, latch wr_sel -> ram_in_sel and wr_data -> ram_in_data.
  - On the transition into READ, latch rd_sel_a -> ram_out_1_sel and rd_sel_b -> ram_out_2_sel.
- WRITE (1 cycle): ram_ce=1, ram_rr=1, wr_ack=1. The RAM writes at the closing edge. Next state is IDLE.
- READ (1 cycle): ram_ce=1, ram_rr=0. The RAM registers both outputs at the closing edge. Next state is CAPTURE.
- CAPTURE (1 cycle): ram_ce=0. ram_out_1/2 hold valid data during this cycle only. At the closing edge, rd_data_a <= ram_out_1 and rd_data_b <= ram_out_2. Next state is RESP.
- RESP (1 cycle): rd_ack=1. Next state is IDLE.
- Outside CAPTURE, ram_out_1/2 are never sampled (they may be Z).
- In all other states, ram_ce=0 and ram_rr=0.
- Latency, counted from the edge that samples the request in IDLE:
  - wr_ack is high in the next cycle; the write is committed at the end of that cycle.
  - rd_ack is high 3 cycles later.
- Throughput: a write every 2 cycles; a read every 4 cycles (IDLE, READ, CAPTURE, RESP).
- Requesters drop their request at the edge after seeing ack, so the following IDLE cycle never re-grants the same transaction.
- rd_data_a/b hold their value until the next CAPTURE.
- ram_*_sel and ram_in_data hold their last latched value; they are don't-care while ram_ce=0.
- Reset (rst_n low, asynchronous, any state):
  - State -> IDLE; last_grant -> READ, so the first tie goes to the write.
  - ram_ce, ram_rr, wr_ack, rd_ack, busy -> 0.
  - All selects, ram_in_data, rd_data_a and rd_data_b -> 0.
  - A write or read in flight is aborted. Because ram_ce drops before the next edge, no partial RAM write occurs.
- Requests asserted during reset are sampled at the first edge after rst_n deasserts.

Test Plan:
- Reset then single write: wr_req, wr_sel=3, wr_data=16'hA5A5 -> ram_ce=1, ram_rr=1, ram_in_sel=3, wr_ack=1 in the next cycle, then IDLE. busy is high for exactly 1 cycle.
- Read-back: write 16'h1234 to address 2 and 16'hBEEF to address 5, then rd_req with a=2, b=5 -> rd_ack 3 cycles after sampling, rd_data_a=16'h1234, rd_data_b=16'hBEEF. ram_ce=1 and ram_rr=0 only in the READ cycle.
- Address conflict: address 4 holds 16'h0001; wr_req (addr 4, 16'h00FF) and rd_req (a=4, b=0) raised in the same cycle -> write granted first, read returns rd_data_a=16'h00FF.
- Round-robin: wr_req and rd_req held continuously with disjoint addresses (write addr 1, read 6/7) -> grants alternate W, R, W, R. No requester waits more than one competing transaction.
- Reset mid-operation: assert rst_n low during the READ cycle -> all outputs 0 immediately, no rd_ack. After release, a fresh read of the same address returns the correct data.
- Reset during the WRITE cycle (addr 0, 16'hDEAD, previous 16'h0000) -> a subsequent read of addr 0 returns 16'h0000.
